// File: rtl/text_overlay_engine.sv
`timescale 1ns/1ps
// Writable character-buffer text overlay: a COLS x ROWS grid of {blink, ascii} cells rendered through
// a synchronous glyph ROM at a fixed origin and scale, with outputs 3 clocks behind x/y.
module text_overlay_engine #(
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned ORG_X      = 64,
  parameter int unsigned ORG_Y      = 192,
  parameter logic [11:0] FG_RGB     = 12'hF00,
  parameter logic [11:0] BG_RGB     = 12'hF8C,
  parameter int unsigned BLINK_DIV  = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_col,
  input  logic [3:0]  wr_row,
  input  logic [6:0]  wr_char,
  input  logic        wr_blink,
  input  logic        clear,
  output logic        busy,
  output logic        text_on,
  output logic [11:0] text_rgb
);

  localparam int unsigned Cells  = COLS * ROWS;
  localparam int unsigned AddrW  = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned Depth  = 1 << AddrW;
  localparam int unsigned CellW  = 8 << SCALE_LOG2;
  localparam int unsigned CellH  = 16 << SCALE_LOG2;
  localparam int unsigned XEnd   = ORG_X + COLS * CellW;
  localparam int unsigned YEnd   = ORG_Y + ROWS * CellH;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  // Glyph rows, row 0 in the top byte, MSB is the leftmost pixel.
  localparam logic [127:0] GlyphA = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
  localparam logic [127:0] GlyphB = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;

  // Resident subset of the shared ascii ROM; unlisted codes render blank.
  function automatic logic [7:0] font_row(input logic [10:0] addr);
    logic [127:0] glyph;
    case (addr[10:4])
      7'h41:   glyph = GlyphA;
      7'h42:   glyph = GlyphB;
      default: glyph = '0;
    endcase
    return glyph[{~addr[3:0], 3'b000} +: 8];
  endfunction

  // ---------------------------------------------------------------- clear FSM
  logic [0:0]       state_q, state_d;
  logic [AddrW-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      StIdle: begin
        if (clear) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        if (clear) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == AddrW'(Cells - 1)) begin
          state_d    = StIdle;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign wr_ready = (state_q == StIdle);
  assign busy     = (state_q == StClear);

  // ---------------------------------------------------------------- cell buffer
  logic [7:0]       mem [Depth];
  logic             wr_in_range;
  logic [AddrW-1:0] wr_addr;
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [7:0]       mem_wdata;

  assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
  assign wr_addr     = AddrW'(32'(wr_row) * COLS + 32'(wr_col));
  assign mem_we      = busy | (wr_valid & wr_ready & wr_in_range);
  assign mem_waddr   = busy ? clr_addr_q : wr_addr;
  assign mem_wdata   = busy ? 8'h00 : {wr_blink, wr_char};

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------- blink phase
  logic [BlinkW-1:0] blink_cnt_q;
  logic              phase_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- S1: window decode
  logic [31:0]      x_w, y_w;
  logic             hit;
  logic [9:0]       dx, dy, col, row;
  logic             hit1_q;
  logic [AddrW-1:0] cell1_q;
  logic [3:0]       grow1_q;
  logic [2:0]       bit1_q;

  assign x_w = {22'b0, x};
  assign y_w = {22'b0, y};
  assign hit = (x_w >= ORG_X) && (x_w < XEnd) && (y_w >= ORG_Y) && (y_w < YEnd);
  assign dx  = x - 10'(ORG_X);
  assign dy  = y - 10'(ORG_Y);
  assign col = dx >> (3 + SCALE_LOG2);
  assign row = dy >> (4 + SCALE_LOG2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit1_q  <= 1'b0;
      cell1_q <= '0;
      grow1_q <= '0;
      bit1_q  <= '0;
    end else begin
      hit1_q  <= hit;
      cell1_q <= AddrW'(32'(row) * COLS + 32'(col));
      grow1_q <= 4'(dy >> SCALE_LOG2);
      bit1_q  <= 3'(dx >> SCALE_LOG2);
    end
  end

  // ---------------------------------------------------------------- S2: ROM lookup
  // Buffer read is combinational off the S1 index, so a same-cycle write is seen next read.
  logic [7:0]  cell_rd;
  logic [10:0] rom_addr;
  logic [7:0]  rom_q;
  logic        hit2_q, blink2_q;
  logic [2:0]  bit2_q;

  assign cell_rd  = mem[cell1_q];
  assign rom_addr = {cell_rd[6:0], grow1_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_q    <= '0;
      hit2_q   <= 1'b0;
      blink2_q <= 1'b0;
      bit2_q   <= '0;
    end else begin
      rom_q    <= font_row(rom_addr);
      hit2_q   <= hit1_q;
      blink2_q <= cell_rd[7];
      bit2_q   <= bit1_q;
    end
  end

  // ---------------------------------------------------------------- S3: pixel out
  logic lit;

  assign lit = hit2_q & rom_q[~bit2_q] & ~(blink2_q & phase_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      text_on  <= 1'b0;
      text_rgb <= BG_RGB;
    end else begin
      text_on  <= lit;
      text_rgb <= lit ? FG_RGB : BG_RGB;
    end
  end

endmodule

// File: tb/tb_text_overlay_engine.sv
`timescale 1ns/1ps
// Directed bench for text_overlay_engine: clear sweep timing, glyph rendering, bounds, blink, reset.
module tb_text_overlay_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x, y;
  logic        frame_tick, wr_valid, wr_ready, wr_blink, clear, busy, text_on;
  logic [5:0]  wr_col;
  logic [3:0]  wr_row;
  logic [6:0]  wr_char;
  logic [11:0] text_rgb;

  always #5 clk = ~clk;

  text_overlay_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (x),
    .y         (y),
    .frame_tick(frame_tick),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_char   (wr_char),
    .wr_blink  (wr_blink),
    .clear     (clear),
    .busy      (busy),
    .text_on   (text_on),
    .text_rgb  (text_rgb)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] font_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                              8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

  typedef struct {
    string       name;
    int          px;
    int          py;
    logic        exp_on;
    logic [11:0] exp_rgb;
  } probe_t;

  probe_t vec [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 'A' in cell (0,0) at 2x scale; everything else blank.
  function automatic logic model_a(input int px, input int py);
    int dx, dy;
    logic [7:0] r;
    if (px < 64 || px >= 80 || py < 192 || py >= 224) return 1'b0;
    dx = px - 64;
    dy = py - 192;
    r  = font_a[(dy / 2) % 16];
    return r[7 - ((dx / 2) % 8)];
  endfunction

  task automatic probe(input string name, input int px, input int py, input logic exp_on);
    @(posedge clk); #1;
    x = 10'(px);
    y = 10'(py);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(name, 32'({text_on, text_rgb}), 32'({exp_on, exp_on ? 12'hF00 : 12'hF8C}));
  endtask

  task automatic wait_idle(output int cyc, output logic ready_seen);
    cyc = 0;
    ready_seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (wr_ready) ready_seen = 1'b1;
    end
  endtask

  task automatic write_cell(input int col, input int row, input logic [6:0] ch, input logic bl);
    logic accepted = 1'b0;
    @(posedge clk); #1;
    wr_col   = 6'(col);
    wr_row   = 4'(row);
    wr_char  = ch;
    wr_blink = bl;
    wr_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check($sformatf("wr_accept_c%0d_r%0d", col, row), 32'(accepted), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic        rdy;
    logic        e;
    logic        exp_q [$];

    reset_n = 1'b0; x = '0; y = '0; frame_tick = 1'b0; wr_valid = 1'b0;
    wr_col = '0; wr_row = '0; wr_char = '0; wr_blink = 1'b0; clear = 1'b0;

    vec[0]  = '{"a_r2_lit",    70,  196, 1'b1, 12'hF00};
    vec[1]  = '{"a_r2_dark",   68,  196, 1'b0, 12'hF8C};
    vec[2]  = '{"a_r7_b0",     64,  206, 1'b1, 12'hF00};
    vec[3]  = '{"a_r7_b6",     77,  207, 1'b1, 12'hF00};
    vec[4]  = '{"a_r7_b7",     78,  207, 1'b0, 12'hF8C};
    vec[5]  = '{"a_r0",        70,  192, 1'b0, 12'hF8C};
    vec[6]  = '{"b_r2_b0",     80,  196, 1'b1, 12'hF00};
    vec[7]  = '{"b_r2_b6",     92,  197, 1'b0, 12'hF8C};
    vec[8]  = '{"b_r6_b1",     82,  204, 1'b1, 12'hF00};
    vec[9]  = '{"left_x63",    63,  196, 1'b0, 12'hF8C};
    vec[10] = '{"mid_x384",    384, 196, 1'b0, 12'hF8C};
    vec[11] = '{"bottom_y320", 70,  320, 1'b0, 12'hF8C};
    vec[12] = '{"right_x704",  704, 196, 1'b0, 12'hF8C};
    vec[13] = '{"col45_drop",  150, 228, 1'b0, 12'hF8C};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_text_on", 32'(text_on), 32'd0);
    check("rst_text_rgb", 32'(text_rgb), 32'hF8C);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);

    // Initial clear sweep length
    @(posedge clk); #1 reset_n = 1'b1;
    wait_idle(cyc, rdy);
    check("init_sweep_cycles", 32'(cyc), 32'd160);
    check("init_ready_in_clear", 32'(rdy), 32'd0);
    check("init_ready_after", 32'(wr_ready), 32'd1);

    // Stream scan of 'A', one new pixel per clock, checked 3 clocks later
    write_cell(0, 0, 7'h41, 1'b0);
    for (int k = 0; k < 640 + 3; k++) begin
      @(posedge clk); #1;
      if (k < 640) begin
        x = 10'(62 + k % 20);
        y = 10'(192 + k / 20);
        exp_q.push_back(model_a(62 + k % 20, 192 + k / 20));
      end
      @(negedge clk);
      if (k >= 3) begin
        e = exp_q.pop_front();
        check($sformatf("scan_k%0d", k - 3), 32'({text_on, text_rgb}),
              32'({e, e ? 12'hF00 : 12'hF8C}));
      end
    end

    // Out-of-range write is accepted but dropped; blinking 'B' beside 'A'
    write_cell(45, 0, 7'h41, 1'b0);
    write_cell(1, 0, 7'h42, 1'b1);
    foreach (vec[i]) begin
      @(posedge clk); #1;
      x = 10'(vec[i].px);
      y = 10'(vec[i].py);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(vec[i].name, 32'({text_on, text_rgb}), 32'({vec[i].exp_on, vec[i].exp_rgb}));
    end

    // Blink phase boundaries
    ticks(29);
    probe("blink_29_shown", 80, 196, 1'b1);
    ticks(1);
    probe("blink_30_hidden", 80, 196, 1'b0);
    probe("blink_30_a_kept", 70, 196, 1'b1);
    ticks(29);
    probe("blink_59_hidden", 80, 196, 1'b0);
    ticks(1);
    probe("blink_60_shown", 80, 196, 1'b1);

    // Clear restarted mid-sweep, with a write held pending throughout
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200 && cyc < 50; i++) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    check("clear_reached_50", 32'(cyc), 32'd50);
    @(posedge clk); #1;
    clear = 1'b1;
    wr_col = 6'd2; wr_row = 4'd0; wr_char = 7'h41; wr_blink = 1'b0; wr_valid = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    wait_idle(cyc, rdy);
    check("restart_sweep_cycles", 32'(cyc), 32'd160);
    check("restart_ready_in_clear", 32'(rdy), 32'd0);
    check("restart_ready_after", 32'(wr_ready), 32'd1);
    @(posedge clk); #1 wr_valid = 1'b0;
    probe("held_write_visible", 102, 196, 1'b1);
    probe("cleared_a", 70, 196, 1'b0);
    probe("cleared_b", 80, 196, 1'b0);

    // Async reset mid-scan with blink phase set
    ticks(30);
    probe("pre_reset_lit", 102, 196, 1'b1);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    check("async_rst_text_on", 32'(text_on), 32'd0);
    check("async_rst_text_rgb", 32'(text_rgb), 32'hF8C);
    check("async_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    wait_idle(cyc, rdy);
    check("post_reset_sweep", 32'(cyc), 32'd160);
    probe("post_reset_c2_clear", 102, 196, 1'b0);
    probe("post_reset_c0_clear", 70, 196, 1'b0);
    write_cell(1, 0, 7'h42, 1'b1);
    probe("post_reset_phase0", 80, 196, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
